// File: rtl/hazard_mon_pkg.sv
// Shared types, rule indices and RV32IMA opcode decode for the pipeline hazard monitor.
package hazard_mon_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    ARMED  = 2'd1,
    FAILED = 2'd2
  } mon_state_t;

  localparam int unsigned NUM_RULES      = 4;
  localparam int unsigned R_STALL_LEN    = 0;
  localparam int unsigned R_BRANCH_STALL = 1;
  localparam int unsigned R_LOAD_USE     = 2;
  localparam int unsigned R_FLUSH_STALL  = 3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH, OPC_AMO};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over en.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_hazard_monitor.sv
// Watches stall/flush/branch control beside the hazard unit and records rule violations
// in sticky flags, saturating per-rule counters and a first-failure snapshot.
module pipeline_hazard_monitor
  import hazard_mon_pkg::*;
#(
  parameter int unsigned MAX_STALL_CYCLES = 2,
  parameter int unsigned WARMUP_CYCLES    = 4,
  parameter int unsigned CNT_W            = 16,
  parameter logic [1:0]  BRANCH_TAKEN     = 2'b01,
  parameter bit          ENABLE_SVA       = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd_ex,
  input  logic                       mem_read_ex,
  input  logic                       stall,
  input  logic                       flush_id,
  input  logic                       flush_ex,
  input  logic [1:0]                 branch_id_s,
  output logic [NUM_RULES-1:0]       err_o,
  output logic                       err_pulse_o,
  output logic [1:0]                 first_rule_o,
  output logic [CNT_W-1:0]           first_cycle_o,
  output logic [NUM_RULES*CNT_W-1:0] viol_cnt_o,
  output logic [CNT_W-1:0]           max_stall_o,
  output logic [1:0]                 state_o
);

  localparam int unsigned WarmW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WarmW-1:0] WarmLast =
      WarmW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  mon_state_t           state_d, state_q;
  logic [WarmW-1:0]     warm_d, warm_q;
  logic [NUM_RULES-1:0] err_d, err_q;
  logic                 pulse_d, pulse_q;
  logic [1:0]           first_rule_d, first_rule_q;
  logic [CNT_W-1:0]     first_cycle_d, first_cycle_q;
  logic [CNT_W-1:0]     max_stall_d, max_stall_q;
  logic [1:0]           branch_q;

  logic [CNT_W-1:0]     run_q, run_nxt, cyc_q;
  logic [NUM_RULES-1:0] rule_hit, viol;
  logic                 active, capture;
  logic [1:0]           lowest;

  // flush_ex is observed but no rule constrains it yet.
  logic unused_flush_ex;
  assign unused_flush_ex = flush_ex;

  assign rule_hit[R_STALL_LEN]    = stall && (run_q == CNT_W'(MAX_STALL_CYCLES));
  assign rule_hit[R_BRANCH_STALL] = (branch_q == BRANCH_TAKEN) && stall;
  assign rule_hit[R_LOAD_USE]     = mem_read_ex && (rd_ex != 5'd0) &&
                                    ((uses_rs1(opcode) && (rs1 == rd_ex)) ||
                                     (uses_rs2(opcode) && (rs2 == rd_ex))) &&
                                    !stall && !flush_id;
  assign rule_hit[R_FLUSH_STALL]  = flush_id && stall;

  assign active  = (state_q != WARMUP) || (WARMUP_CYCLES == 0);
  assign viol    = active ? rule_hit : '0;
  // Value the run counter takes at this edge; lets max_stall track it without lag.
  assign run_nxt = !stall ? '0 : ((run_q == '1) ? run_q : run_q + CNT_W'(1));

  always_comb begin
    lowest = 2'd0;
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      if (viol[k]) lowest = 2'(k);
    end
  end

  always_comb begin
    state_d       = state_q;
    warm_d        = warm_q;
    capture       = 1'b0;
    err_d         = err_q | viol;
    pulse_d       = |viol;
    first_rule_d  = first_rule_q;
    first_cycle_d = first_cycle_q;
    max_stall_d   = max_stall_q;

    unique case (state_q)
      WARMUP: begin
        if (WARMUP_CYCLES == 0) begin
          state_d = (|viol) ? FAILED : ARMED;
          capture = |viol;
        end else if (warm_q == WarmLast) begin
          state_d = ARMED;
        end else begin
          warm_d = warm_q + WarmW'(1);
        end
      end
      ARMED: begin
        if (|viol) begin
          state_d = FAILED;
          capture = 1'b1;
        end
      end
      FAILED:  state_d = FAILED;
      default: state_d = WARMUP;
    endcase

    if (capture) begin
      first_rule_d  = lowest;
      first_cycle_d = cyc_q;
    end
    if (active && (run_nxt > max_stall_q)) begin
      max_stall_d = run_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WARMUP;
      warm_q        <= '0;
      err_q         <= '0;
      pulse_q       <= 1'b0;
      first_rule_q  <= '0;
      first_cycle_q <= '0;
      max_stall_q   <= '0;
      branch_q      <= '0;
    end else begin
      state_q       <= state_d;
      warm_q        <= warm_d;
      err_q         <= err_d;
      pulse_q       <= pulse_d;
      first_rule_q  <= first_rule_d;
      first_cycle_q <= first_cycle_d;
      max_stall_q   <= max_stall_d;
      branch_q      <= branch_id_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (stall),
    .clr_i (!stall),
    .q_o   (run_q)
  );

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (active),
    .clr_i (1'b0),
    .q_o   (cyc_q)
  );

  for (genvar k = 0; k < NUM_RULES; k++) begin : g_viol_cnt
    sat_counter #(.W(CNT_W)) u_viol_cnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (viol[k]),
      .clr_i (1'b0),
      .q_o   (viol_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  assign err_o         = err_q;
  assign err_pulse_o   = pulse_q;
  assign first_rule_o  = first_rule_q;
  assign first_cycle_o = first_cycle_q;
  assign max_stall_o   = max_stall_q;
  assign state_o       = state_q;

  if (ENABLE_SVA) begin : g_sva
    r0_stall_len: assert property (@(posedge clk) disable iff (reset || state_q == WARMUP)
        !rule_hit[R_STALL_LEN]);
    r1_branch_stall: assert property (@(posedge clk) disable iff (reset || state_q == WARMUP)
        !rule_hit[R_BRANCH_STALL]);
    r2_load_use: assert property (@(posedge clk) disable iff (reset || state_q == WARMUP)
        !rule_hit[R_LOAD_USE]);
    r3_flush_stall: assert property (@(posedge clk) disable iff (reset || state_q == WARMUP)
        !rule_hit[R_FLUSH_STALL]);
  end

endmodule

// File: tb/tb_pipeline_hazard_monitor.sv
// Directed bench: expectations are queued with each stimulus step and checked after the edge.
module tb_pipeline_hazard_monitor;
  import hazard_mon_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned WS = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1, rs2, rd_ex;
  logic [6:0] opcode;
  logic mem_read_ex, stall, flush_id, flush_ex;
  logic [1:0] branch_id_s;

  logic [3:0]      err, err_s;
  logic            pulse, pulse_s;
  logic [1:0]      frule, frule_s, state, state_s;
  logic [W-1:0]    fcyc, maxst;
  logic [4*W-1:0]  vcnt;
  logic [WS-1:0]   fcyc_s, maxst_s;
  logic [4*WS-1:0] vcnt_s;

  always #5 clk = ~clk;

  pipeline_hazard_monitor #(
    .MAX_STALL_CYCLES (2), .WARMUP_CYCLES (4), .CNT_W (W),
    .BRANCH_TAKEN (2'b01), .ENABLE_SVA (1'b0)
  ) dut (
    .clk (clk), .reset (reset), .rs1 (rs1), .rs2 (rs2), .opcode (opcode), .rd_ex (rd_ex),
    .mem_read_ex (mem_read_ex), .stall (stall), .flush_id (flush_id), .flush_ex (flush_ex),
    .branch_id_s (branch_id_s), .err_o (err), .err_pulse_o (pulse), .first_rule_o (frule),
    .first_cycle_o (fcyc), .viol_cnt_o (vcnt), .max_stall_o (maxst), .state_o (state)
  );

  pipeline_hazard_monitor #(
    .MAX_STALL_CYCLES (2), .WARMUP_CYCLES (4), .CNT_W (WS),
    .BRANCH_TAKEN (2'b01), .ENABLE_SVA (1'b0)
  ) dut_s (
    .clk (clk), .reset (reset), .rs1 (rs1), .rs2 (rs2), .opcode (opcode), .rd_ex (rd_ex),
    .mem_read_ex (mem_read_ex), .stall (stall), .flush_id (flush_id), .flush_ex (flush_ex),
    .branch_id_s (branch_id_s), .err_o (err_s), .err_pulse_o (pulse_s),
    .first_rule_o (frule_s), .first_cycle_o (fcyc_s), .viol_cnt_o (vcnt_s),
    .max_stall_o (maxst_s), .state_o (state_s)
  );

  typedef enum int {FErr, FPulse, FState, FRule, FCyc, FV0, FV1, FV2, FV3, FMax, FSmallV3}
    fld_e;
  typedef struct {
    string       tag;
    fld_e        fld;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [63:0] get_obs(input fld_e f);
    case (f)
      FErr:     return 64'(err);
      FPulse:   return 64'(pulse);
      FState:   return 64'(state);
      FRule:    return 64'(frule);
      FCyc:     return 64'(fcyc);
      FV0:      return 64'(vcnt[0*W +: W]);
      FV1:      return 64'(vcnt[1*W +: W]);
      FV2:      return 64'(vcnt[2*W +: W]);
      FV3:      return 64'(vcnt[3*W +: W]);
      FMax:     return 64'(maxst);
      FSmallV3: return 64'(vcnt_s[3*WS +: WS]);
      default:  return 64'hx;
    endcase
  endfunction

  task automatic exp1(input string tag, input fld_e f, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp3(input string tag, input logic [3:0] e, input logic p, input mon_state_t s);
    exp1({tag, ".err"}, FErr, 64'(e));
    exp1({tag, ".pulse"}, FPulse, 64'(p));
    exp1({tag, ".state"}, FState, 64'(s));
  endtask

  task automatic tick();
    exp_t  e;
    logic [63:0] obs;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = get_obs(e.fld);
      n_cmp++;
      assert (obs === e.exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd_ex = 5'd0; opcode = 7'd0; mem_read_ex = 1'b0;
    stall = 1'b0; flush_id = 1'b0; flush_ex = 1'b0; branch_id_s = 2'b00;
  endtask

  task automatic rearm();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    exp1("rearm.state", FState, 64'(ARMED));
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    exp3("rst", 4'h0, 1'b0, WARMUP);
    exp1("rst.frule", FRule, 0);
    exp1("rst.fcyc", FCyc, 0);
    exp1("rst.v0", FV0, 0);
    exp1("rst.max", FMax, 0);
    tick();

    // T1: stalls during warmup are ignored
    reset = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp3("t1.warm", 4'h0, 1'b0, WARMUP);
      tick();
    end
    stall = 1'b0;
    exp3("t1.arm", 4'h0, 1'b0, ARMED);
    tick();

    // T2: 2-cycle stall legal, 3-cycle stall trips R0
    stall = 1'b1; exp1("t2.max1", FMax, 1); tick();
    exp3("t2.s2", 4'h0, 1'b0, ARMED); exp1("t2.max2", FMax, 2); tick();
    stall = 1'b0; exp3("t2.gap", 4'h0, 1'b0, ARMED); tick();
    stall = 1'b1; tick();
    exp3("t2.s2b", 4'h0, 1'b0, ARMED); tick();
    exp3("t2.s3", 4'h1, 1'b1, FAILED);
    exp1("t2.max3", FMax, 3);
    exp1("t2.frule", FRule, 0);
    exp1("t2.fcyc", FCyc, 5);
    exp1("t2.v0", FV0, 1);
    tick();
    stall = 1'b0; exp3("t2.after", 4'h1, 1'b0, FAILED); tick();

    // T3: taken branch followed by stall
    rearm();
    branch_id_s = 2'b01; stall = 1'b1;
    exp3("t3.same", 4'h0, 1'b0, ARMED); tick();
    branch_id_s = 2'b00;
    exp3("t3.hit", 4'h2, 1'b1, FAILED);
    exp1("t3.frule", FRule, 1);
    exp1("t3.fcyc", FCyc, 1);
    exp1("t3.v1", FV1, 1);
    tick();
    idle(); exp1("t3.gap", FPulse, 0); tick();
    branch_id_s = 2'b01; exp1("t3.br2", FPulse, 0); tick();
    branch_id_s = 2'b00; stall = 1'b1;
    exp3("t3.hit2", 4'h2, 1'b1, FAILED);
    exp1("t3.v1b", FV1, 2);
    exp1("t3.frule2", FRule, 1);
    exp1("t3.fcyc2", FCyc, 1);
    tick();
    idle();
    tick();

    // T4: load-use without a stall
    rearm();
    mem_read_ex = 1'b1; rd_ex = 5'd5; opcode = OPC_OP; rs2 = 5'd5;
    exp3("t4.op", 4'h4, 1'b1, FAILED);
    exp1("t4.frule", FRule, 2);
    exp1("t4.fcyc", FCyc, 0);
    exp1("t4.v2", FV2, 1);
    tick();
    opcode = OPC_OP_IMM; exp1("t4.opimm_rs2", FPulse, 0); tick();
    opcode = OPC_OP; rd_ex = 5'd0; rs2 = 5'd0; exp1("t4.x0", FPulse, 0); tick();
    opcode = OPC_LUI; rd_ex = 5'd5; rs1 = 5'd5; exp1("t4.lui", FPulse, 0); tick();
    opcode = OPC_OP_IMM;
    exp1("t4.opimm_rs1", FPulse, 1); exp1("t4.v2b", FV2, 2); tick();
    stall = 1'b1; exp1("t4.stalled", FPulse, 0); tick();
    stall = 1'b0; flush_id = 1'b1;
    exp1("t4.flushed", FPulse, 0); exp1("t4.v2c", FV2, 2); tick();
    idle();
    tick();

    // T5: flush+stall on the overflow cycle, lowest rule wins
    rearm();
    stall = 1'b1; tick();
    tick();
    flush_id = 1'b1;
    exp3("t5.hit", 4'h9, 1'b1, FAILED);
    exp1("t5.frule", FRule, 0);
    exp1("t5.fcyc", FCyc, 2);
    exp1("t5.v0", FV0, 1);
    exp1("t5.v3", FV3, 1);
    tick();
    idle();
    tick();

    // T6: one-cycle reset from FAILED, then counter saturation on the narrow instance
    reset = 1'b1;
    exp3("t6.rst", 4'h0, 1'b0, WARMUP);
    exp1("t6.frule", FRule, 0);
    exp1("t6.fcyc", FCyc, 0);
    exp1("t6.v0", FV0, 0);
    exp1("t6.v3", FV3, 0);
    exp1("t6.max", FMax, 0);
    exp1("t6.sv3", FSmallV3, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    exp1("t6.arm", FState, 64'(ARMED));
    tick();
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1; flush_id = 1'b1; tick();
      idle(); tick();
    end
    exp1("t6.v3_wide", FV3, 5);
    exp1("t6.v3_sat", FSmallV3, 3);
    exp1("t6.err", FErr, 8);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
